seq_alu: RTL and testbench

- Parametrised WIDTH-bit ALU with registered results and flags, plus a multi-cycle unsigned shift-add multiply.
- Keeps the existing 3-bit operation encoding and adds a MUL opcode in the previously unused slot 001.
- Sits between register read and writeback. The datapath or control FSM drives it through valid/ready handshakes on both input and output.
- Flags (negative, zero, overflow, carry) feed the flag register for LEGv8 conditional branches.

---
 rtl/seq_alu.sv | 168 ++++++++++++++++
 tb/tb_seq_alu.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with flags, plus a multi-cycle unsigned shift-add multiply.
// Both the input side and the output side use valid/ready handshakes.
module seq_alu #(
    parameter int  WIDTH = 64,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 neg_q, neg_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;
    logic                 cry_q, cry_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 accept;
    logic                 sub_op;
    logic [WIDTH-1:0]     b_eff;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_ovf;
    logic                 alu_cry;
    logic [2*WIDTH-1:0]   mul_acc;

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Subtract is A + ~B + 1, so carry_out=1 means no borrow.
    always_comb begin
        sub_op  = (sel == OP_SUB);
        b_eff   = sub_op ? ~B : B;
        sum     = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_cry = 1'b0;
        case (sel)
            OP_PASS: alu_res = B;
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_cry = sum[WIDTH];
                alu_ovf = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            default: alu_res = '0;
        endcase
    end

    assign mul_acc = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        cry_d       = cry_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (sel == OP_MUL) begin
                        acc_d       = '0;
                        mcand_d     = {{WIDTH{1'b0}}, A};
                        mplier_d    = B;
                        cnt_d       = CNT_W'(WIDTH);
                        out_valid_d = 1'b0;
                        state_d     = S_MUL;
                    end else begin
                        result_d    = alu_res;
                        ovf_d       = alu_ovf;
                        cry_d       = alu_cry;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end else if ((state_q == S_DONE) && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d    = mul_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                // Final iteration: publish the low half, flag any bits left in the high half.
                if (cnt_q == CNT_W'(1)) begin
                    result_d    = mul_acc[WIDTH-1:0];
                    ovf_d       = |mul_acc[2*WIDTH-1:WIDTH];
                    cry_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        neg_d  = result_d[WIDTH-1];
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cry_q       <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            neg_q       <= neg_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            cry_q       <= cry_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry_out = cry_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: an 8-bit and a 64-bit instance share clock and reset.
module tb_seq_alu;

    logic        clk;
    logic        reset;

    logic        iv8, ir8, ov8, or8, n8, z8, v8, c8;
    logic [7:0]  a8, b8, r8;
    logic [2:0]  sel8;

    logic        iv64, ir64, ov64, or64, n64, z64, v64, c64;
    logic [63:0] a64, b64, r64;
    logic [2:0]  sel64;

    int total = 0;
    int bad   = 0;
    int n;

    seq_alu #(.WIDTH(8)) u_alu8 (
        .clk(clk), .reset(reset),
        .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8), .sel(sel8),
        .out_valid(ov8), .out_ready(or8), .result(r8),
        .negative(n8), .zero(z8), .overflow(v8), .carry_out(c8)
    );

    seq_alu #(.WIDTH(64)) u_alu64 (
        .clk(clk), .reset(reset),
        .in_valid(iv64), .in_ready(ir64), .A(a64), .B(b64), .sel(sel64),
        .out_valid(ov64), .out_ready(or64), .result(r64),
        .negative(n64), .zero(z64), .overflow(v64), .carry_out(c64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        a8 = a; b8 = b; sel8 = s; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
    endtask

    task automatic drain8();
        iv8 = 1'b0; or8 = 1'b1;
        tick();
        chk("drain8_valid", {63'd0, ov8}, 64'd0);
    endtask

    task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic [2:0] s);
        a64 = a; b64 = b; sel64 = s; iv64 = 1'b1;
        tick();
        iv64 = 1'b0;
    endtask

    task automatic chk8(input string tag, input logic [7:0] r, input logic n_e,
                        input logic z_e, input logic v_e, input logic c_e);
        chk({tag, "_valid"}, {63'd0, ov8}, 64'd1);
        chk({tag, "_res"},   {56'd0, r8},  {56'd0, r});
        chk({tag, "_flags"}, {60'd0, n8, z8, v8, c8}, {60'd0, n_e, z_e, v_e, c_e});
    endtask

    initial begin
        reset = 1'b1;
        iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; sel8 = '0;
        iv64 = 1'b0; or64 = 1'b1; a64 = '0; b64 = '0; sel64 = '0;
        repeat (2) tick();
        chk("rst_valid", {63'd0, ov8}, 64'd0);
        chk("rst_res", {56'd0, r8}, 64'd0);
        chk("rst_flags", {60'd0, n8, z8, v8, c8}, 64'd0);
        reset = 1'b0;
        tick();
        chk("rst_in_ready", {63'd0, ir8}, 64'd1);

        // Add with signed overflow, latency 1
        op8(8'h7F, 8'h01, 3'b010);
        chk8("add_ovf", 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);
        drain8();
        op8(8'h35, 8'h35, 3'b011);
        chk8("sub_zero", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        drain8();
        op8(8'h00, 8'h01, 3'b011);
        chk8("sub_borrow", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        drain8();

        // Multiply: 0x0D*0x0B = 0x8F; valid WIDTH edges after the accepting edge
        op8(8'h0D, 8'h0B, 3'b001);
        chk("mul1_in_ready", {63'd0, ir8}, 64'd0);
        n = 0;
        while (!ov8 && n < 200) begin tick(); n++; end
        chk("mul1_lat", 64'(n), 64'd8);
        chk8("mul1", 8'h8F, 1'b1, 1'b0, 1'b0, 1'b0);
        // Accepted straight out of DONE: 0x20*0x10 = 0x200
        op8(8'h20, 8'h10, 3'b001);
        chk("mul2_drop", {63'd0, ov8}, 64'd0);
        n = 0;
        while (!ov8 && n < 200) begin tick(); n++; end
        chk("mul2_lat", 64'(n), 64'd8);
        chk8("mul2", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        drain8();

        // Backpressure: XOR held while the next op waits at the input
        or8 = 1'b0;
        op8(8'hF0, 8'h3C, 3'b110);
        a8 = 8'hF0; b8 = 8'h3C; sel8 = 3'b100; iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk8("xor_hold", 8'hCC, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("xor_in_ready", {63'd0, ir8}, 64'd0);
            tick();
        end
        chk8("xor_hold_end", 8'hCC, 1'b1, 1'b0, 1'b0, 1'b0);
        or8 = 1'b1;
        tick();
        chk8("b2b_and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        sel8 = 3'b101;
        tick();
        chk8("b2b_or", 8'hFC, 1'b1, 1'b0, 1'b0, 1'b0);
        sel8 = 3'b000;
        tick();
        chk8("b2b_pass", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        sel8 = 3'b111;
        tick();
        chk8("b2b_zero", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        drain8();

        // Reset three cycles into a multiply, with a nonzero result still in the register
        op8(8'h12, 8'h34, 3'b010);
        chk8("pre_add", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
        drain8();
        op8(8'h0D, 8'h0B, 3'b001);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("midrst_valid", {63'd0, ov8}, 64'd0);
        chk("midrst_res", {56'd0, r8}, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("postrst_in_ready", {63'd0, ir8}, 64'd1);
        chk("postrst_valid", {63'd0, ov8}, 64'd0);
        op8(8'h0F, 8'hA0, 3'b101);
        chk8("postrst_or", 8'hAF, 1'b1, 1'b0, 1'b0, 1'b0);
        drain8();

        // 64-bit instance
        op64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b010);
        chk("w64_add_valid", {63'd0, ov64}, 64'd1);
        chk("w64_add_res", r64, 64'd0);
        chk("w64_add_flags", {60'd0, n64, z64, v64, c64}, {60'd0, 4'b0101});
        or64 = 1'b1;
        tick();
        op64(64'h1_0000_0000, 64'h1_0000_0000, 3'b001);
        chk("w64_mul_drop", {63'd0, ov64}, 64'd0);
        n = 0;
        while (!ov64 && n < 500) begin tick(); n++; end
        chk("w64_mul_lat", 64'(n), 64'd64);
        chk("w64_mul_res", r64, 64'd0);
        chk("w64_mul_flags", {60'd0, n64, z64, v64, c64}, {60'd0, 4'b0110});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
